// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and data access
// Optional watchdog: define ARB_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_next;
  logic            owner_d;
  logic            grant_d, grant_i;
  logic            timeout;
  logic [SW-1:0]   starve_cnt;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == ACCESS) ? to_cnt + TW'(1) : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  // Fires on the last permitted ACCESS cycle so m_req is high for exactly TIMEOUT_CYCLES
  assign timeout = (state == ACCESS) && !m_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || (int'(starve_cnt) < STARVE_LIMIT))) begin
          grant_d    = 1'b1;
          state_next = ACCESS;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: if (m_ready || timeout) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_d    <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_d || grant_i) begin
        owner_d <= grant_d;
        m_we    <= grant_d & d_we;
        m_addr  <= grant_d ? d_addr : i_addr;
        m_wdata <= grant_d ? d_wdata : '0;
      end
      // Only D wins against a waiting I count toward starvation
      if (grant_d && i_req) begin
        if (int'(starve_cnt) < STARVE_LIMIT) starve_cnt <= starve_cnt + SW'(1);
      end else if (grant_d || grant_i) begin
        starve_cnt <= '0;
      end
      if (state == ACCESS && m_ready) begin
        if (owner_d) d_rdata <= m_rdata;
        else         i_rdata <= m_rdata;
      end else if (timeout) begin
        if (owner_d) d_rdata <= DATA_WIDTH'(32'hDEADBEEF);
        else         i_rdata <= DATA_WIDTH'(32'hDEADBEEF);
      end
    end
  end

  assign m_req   = (state == ACCESS);
  assign busy    = (state != IDLE);
  assign i_ready = (state == RESP) && !owner_d;
  assign d_ready = (state == RESP) && owner_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized check of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ready, d_req, d_we, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready, busy, err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: where the arbiter is in its access (0 free, 1 memory busy, 2 answering)
  int          phase, sc, acc_cycles, p_i, p_d, quiet;
  bit          own_d, pending_rst, rst_hold;
  logic        e_mreq, e_busy, e_iready, e_dready, e_mwe, e_err;
  logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;

  task automatic model_clear();
    phase = 0; sc = 0; acc_cycles = 0; own_d = 0;
    e_mreq = 0; e_busy = 0; e_iready = 0; e_dready = 0; e_err = 0;
    e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_irdata = 0; e_drdata = 0;
  endtask

  task automatic check_all();
    check("m_req", m_req, e_mreq);
    check("busy", busy, e_busy);
    check("i_ready", i_ready, e_iready);
    check("d_ready", d_ready, e_dready);
    check("i_rdata", i_rdata, e_irdata);
    check("d_rdata", d_rdata, e_drdata);
    check("err", err, e_err);
    if (e_mreq) begin
      check("m_addr", m_addr, e_maddr);
      check("m_we", m_we, e_mwe);
      check("m_wdata", m_wdata, e_mwdata);
    end
  endtask

  task automatic model_step();
    e_iready = 0;
    e_dready = 0;
    if (phase == 0) begin
      if (d_req && (!i_req || sc < SL)) begin
        own_d = 1;
        sc = i_req ? ((sc < SL) ? sc + 1 : sc) : 0;
        e_maddr = d_addr; e_mwe = d_we; e_mwdata = d_wdata;
        phase = 1; acc_cycles = 0;
      end else if (i_req) begin
        own_d = 0; sc = 0;
        e_maddr = i_addr; e_mwe = 0; e_mwdata = 0;
        phase = 1; acc_cycles = 0;
      end
    end else if (phase == 1) begin
      if (m_ready) begin
        if (own_d) e_drdata = m_rdata; else e_irdata = m_rdata;
        e_dready = own_d; e_iready = !own_d;
        phase = 2;
      end else begin
        acc_cycles++;
`ifdef ARB_TIMEOUT_EN
        if (acc_cycles == TO) begin
          if (own_d) e_drdata = 32'hDEADBEEF; else e_irdata = 32'hDEADBEEF;
          e_dready = own_d; e_iready = !own_d;
          e_err = 1;
          phase = 2;
        end
`endif
      end
    end else begin
      phase = 0;
    end
    e_mreq = (phase == 1);
    e_busy = (phase != 0);
  endtask

  initial begin
    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rdata = 0;
    pending_rst = 0; rst_hold = 0; quiet = 0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_m_we", m_we, 1'b0);
    reset = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst_hold) begin
        reset = 0;
        rst_hold = 0;
      end
      check_all();
      if (cyc < 1000)      begin p_i = 40;  p_d = 40;  end
      else if (cyc < 1600) begin p_i = 100; p_d = 100; end
      else                 begin p_i = 30;  p_d = 50;  end
      if (cyc == 1800) pending_rst = 1;
      if (pending_rst && phase == 1) begin
        reset = 1;
        #1;
        check("arst_m_req", m_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_i_ready", i_ready, 1'b0);
        check("arst_d_ready", d_ready, 1'b0);
        check("arst_m_addr", m_addr, 32'h0);
        check("arst_i_rdata", i_rdata, 32'h0);
        check("arst_d_rdata", d_rdata, 32'h0);
        model_clear();
        i_req = 0; d_req = 0; m_ready = 0;
        pending_rst = 0; rst_hold = 1; quiet = 6;
        continue;
      end
      if (e_iready) i_req = 0;
      if (e_dready) d_req = 0;
      if (quiet > 0) begin
        quiet--;
      end else begin
        if (!i_req && $urandom_range(99) < p_i) begin
          i_req = 1;
          i_addr = {1'b0, 31'($urandom)};
        end
        if (!d_req && $urandom_range(99) < p_d) begin
          d_req = 1;
          d_we = 1'($urandom);
          d_addr = {1'b1, 31'($urandom)};
          d_wdata = $urandom;
        end
      end
      m_ready = ($urandom_range(99) < ((phase == 1) ? 35 : 20));
      m_rdata = $urandom;
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
